nqueen_solver: RTL and testbench
================================

Name: nqueen_solver

Overview:
Parametrised successor to the 8-queen datapath. It is a self-contained N-queens backtracking engine: datapath plus internal controller in one block. Queen positions are held as binary column indices per row, not one-hot shift registers. Finished solutions stream out one row per beat over a valid/ready handshake, as one-hot row words. The block sits between the top-level start/done control and the board-output consumer that previously read out_bus.

Parameters:
N, 8, board size (rows = columns); legal range 1..16
COUNT_W, 16, width of the solution counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clears all state
start  in  1  pulse; begins a search when state is IDLE or DONE
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  high while in DONE; holds until next start or reset
found  out  1  high in DONE if at least one solution was emitted
out_valid  out  1  row beat valid
out_ready  in  1  consumer accepts beat
out_row  out  N  one-hot queen position of current row; bit c = column c
out_row_idx  out  $clog2(N) (min 1)  row number of the current beat
out_last  out  1  high on the beat for row N-1
sol_count  out  COUNT_W  number of solutions fully emitted; saturates at all-ones

Behaviour:
- Reset values: all outputs 0; state IDLE; row pointer and all col[] cleared. Takes effect on any cycle, including mid-search and mid-emit. out_valid drops the next cycle with no partial-beat completion.
- ROW_W = max(1, $clog2(N)). Column and row registers are ROW_W bits. Comparisons are unsigned. Diagonal test is |r1-r2| == |c1-c2|, computed at ROW_W+1 bits.
- State machine states: IDLE, CHECK, ADVANCE, BACKTRACK, EMIT, DONE.
- IDLE/DONE + start: row=0, col[0]=0, k=row-1 (invalid when row=0), sol_count=0, found=0 → CHECK.
- start seen in any other state is ignored.
- CHECK: one comparison per cycle, col[row] against col[k], with k descending from row-1 to 0.
  - row=0 is safe in its first CHECK cycle.
  - On conflict → ADVANCE.
  - All k clear, row<N-1: row++, col[row]=0 → CHECK.
  - All k clear, row=N-1 → EMIT.
- ADVANCE:
  - col[row]<N-1: col[row]++ → CHECK.
  - Otherwise → BACKTRACK.
- BACKTRACK:
  - row=0 → DONE (search exhausted).
  - Otherwise row-- → ADVANCE.
- EMIT: beats i=0..N-1, with out_row=onehot(col[i]), out_row_idx=i, out_last=(i==N-1).
  - out_valid rises the cycle after entering EMIT.
  - A beat transfers on out_valid&&out_ready.
  - While out_ready=0, all out_* hold stable.
  - out_valid is never withdrawn once raised.
  - Back-to-back beats are allowed; throughput is 1 beat/cycle.
- On acceptance of the last beat: found=1, sol_count++ (saturating), then follow the Optional Feature rule.
- Boundaries:
  - N=1 yields one solution (out_row=1'b1).
  - N=2 and N=3 reach DONE with found=0, sol_count=0, and no beats.
  - out_ready is ignored outside EMIT.

Optional Feature:
Macro NQUEEN_FIND_ALL_EN.
- Defined: after the last beat of a solution, continue the search (→ ADVANCE at row N-1). DONE is reached only on exhaustion, and sol_count is the total solution count.
- Undefined: after the first solution's last beat → DONE. sol_count ≤ 1; the backtracking exhaustion path still applies when no solution exists.

Decomposition:
- Package nqueen_pkg holds:
  - state enum type
  - function row_width(n) returning max(1,$clog2(n))
  - MAX_N=16 constant
- One sub-module: nqueen_conflict_check.
  - Combinational; inputs (r1,c1,r2,c2), output conflict (same column or same diagonal).
  - Parametrised on ROW_W; successor of the old safety checker.

Test Plan:
- N=8, macro off, out_ready=1, pulse start → 8 beats with columns 0,4,7,5,2,6,1,3 (out_row 8'h01,8'h10,8'h80,8'h20,8'h04,8'h40,8'h02,8'h08); out_last on 8th; then done=1, found=1, sol_count=1.
- N=4, macro on → two solutions in order (1,3,0,2) then (2,0,3,1); done=1, sol_count=2.
- N=8, macro on, out_ready=1 → 92 solutions emitted, each checked against a reference model; sol_count=92.
- N=3, start → done=1, found=0, sol_count=0, out_valid never asserted; N=1 → single beat out_row=1'b1, out_last=1.
- N=8 backpressure: hold out_ready=0 for 5 cycles at beat 3 → out_row/out_row_idx/out_last stable and out_valid held high; the beat completes when ready rises; no beat lost or duplicated.
- Reset mid-CHECK and mid-EMIT, plus start while busy → start during busy ignored; after reset all outputs are 0 and state is IDLE; a fresh start then reproduces the first test's first solution exactly.

Source files
------------

// File: rtl/nqueen_pkg.sv
// Shared types and helpers for the N-queens backtracking engine.
package nqueen_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ADVANCE,
    BACKTRACK,
    EMIT,
    DONE
  } state_t;

  function automatic int row_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nqueen_conflict_check.sv
// Combinational attack test between two queens: same column or same diagonal.
module nqueen_conflict_check #(
  parameter int ROW_W = 3
) (
  input  logic [ROW_W-1:0] r1,
  input  logic [ROW_W-1:0] c1,
  input  logic [ROW_W-1:0] r2,
  input  logic [ROW_W-1:0] c2,
  output logic             conflict
);

  logic [ROW_W:0] dr;
  logic [ROW_W:0] dc;

  always_comb begin
    dr = (r1 >= r2) ? ({1'b0, r1} - {1'b0, r2}) : ({1'b0, r2} - {1'b0, r1});
    dc = (c1 >= c2) ? ({1'b0, c1} - {1'b0, c2}) : ({1'b0, c2} - {1'b0, c1});
    conflict = (c1 == c2) || (dr == dc);
  end

endmodule

// File: rtl/nqueen_solver.sv
// N-queens backtracking engine streaming solutions as one-hot row beats.
// NQUEEN_FIND_ALL_EN: keep searching after each solution instead of stopping at the first.
//   state     | meaning
//   IDLE      | waiting for start after reset
//   CHECK     | compare col[row] against col[k], k descending to 0
//   ADVANCE   | move queen of current row one column right
//   BACKTRACK | current row exhausted, step back a row
//   EMIT      | stream col[0..N-1] as one-hot beats
//   DONE      | search finished, results held until next start
module nqueen_solver
  import nqueen_pkg::*;
#(
  parameter int N       = 8,
  parameter int COUNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_row,
  output logic [row_width(N)-1:0] out_row_idx,
  output logic                    out_last,
  output logic [COUNT_W-1:0]      sol_count
);

  localparam int ROW_W = row_width(N);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(N - 1);

  if (N < 1 || N > MAX_N) begin : g_bad_n
    $error("nqueen_solver: N must be in 1..16");
  end

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] k;
  logic [ROW_W-1:0] col [N];
  logic [ROW_W-1:0] next_row;
  logic [ROW_W-1:0] next_idx;
  logic             conflict;

  assign next_row = row + 1'b1;
  assign next_idx = out_row_idx + 1'b1;

  nqueen_conflict_check #(.ROW_W(ROW_W)) u_check (
    .r1       (row),
    .c1       (col[row]),
    .r2       (k),
    .c2       (col[k]),
    .conflict (conflict)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row         <= '0;
      k           <= '0;
      for (int i = 0; i < N; i++) col[i] <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
      out_last    <= 1'b0;
      sol_count   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            row       <= '0;
            col[0]    <= '0;
            k         <= '0;
            sol_count <= '0;
            found     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          // row 0 has nothing above it; otherwise k walks down to 0
          if (row != '0 && conflict) begin
            state <= ADVANCE;
          end else if (row == '0 || k == '0) begin
            if (row == LAST) begin
              state <= EMIT;
            end else begin
              row           <= next_row;
              col[next_row] <= '0;
              k             <= row;
            end
          end else begin
            k <= k - 1'b1;
          end
        end
        ADVANCE: begin
          if (col[row] != LAST) begin
            col[row] <= col[row] + 1'b1;
            k        <= row - 1'b1;
            state    <= CHECK;
          end else begin
            state <= BACKTRACK;
          end
        end
        BACKTRACK: begin
          if (row == '0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            row   <= row - 1'b1;
            state <= ADVANCE;
          end
        end
        EMIT: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            out_row     <= N'(1) << col[0];
            out_row_idx <= '0;
            out_last    <= (LAST == '0);
          end else if (out_ready) begin
            if (out_last) begin
              out_valid   <= 1'b0;
              out_row     <= '0;
              out_row_idx <= '0;
              out_last    <= 1'b0;
              found       <= 1'b1;
              if (sol_count != '1) sol_count <= sol_count + 1'b1;
`ifdef NQUEEN_FIND_ALL_EN
              state       <= ADVANCE;
`else
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
`endif
            end else begin
              out_row     <= N'(1) << col[next_idx];
              out_row_idx <= next_idx;
              out_last    <= (next_idx == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nqueen_solver.sv
// Scoreboard bench for nqueen_solver at N = 8, 4, 3 and 1.
module tb_nqueen_solver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_v [4];
  logic        ready_v [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        found_v [4];
  logic        valid_v [4];
  logic        last_v  [4];
  logic [15:0] cnt_v   [4];
  logic [15:0] row_v   [4];
  logic [3:0]  idx_v   [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NS = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 3 : 1;
    localparam int RW = (NS > 1) ? $clog2(NS) : 1;
    logic [NS-1:0] r;
    logic [RW-1:0] ix;
    nqueen_solver #(.N(NS), .COUNT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start_v[g]),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .found       (found_v[g]),
      .out_valid   (valid_v[g]),
      .out_ready   (ready_v[g]),
      .out_row     (r),
      .out_row_idx (ix),
      .out_last    (last_v[g]),
      .sol_count   (cnt_v[g])
    );
    assign row_v[g] = 16'(r);
    assign idx_v[g] = 4'(ix);
  end

  int vectors = 0;
  int miscompares = 0;
  logic [20:0] exp_q [$];
  logic [63:0] sols [$];

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 4 : (d == 2) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: iterative row-by-row search, leftmost column first
  task automatic build_solutions(input int n);
    int c [16];
    int r;
    bit ok;
    logic [63:0] p;
    sols.delete();
    r = 0;
    c[0] = 0;
    while (r >= 0) begin
      if (c[r] >= n) begin
        r--;
        if (r >= 0) c[r]++;
      end else begin
        ok = 1'b1;
        for (int j = 0; j < r; j++)
          if (c[j] == c[r] || c[j] - c[r] == r - j || c[r] - c[j] == r - j) ok = 1'b0;
        if (!ok) c[r]++;
        else if (r == n - 1) begin
          p = '0;
          for (int j = 0; j < n; j++) p[4*j +: 4] = 4'(c[j]);
          sols.push_back(p);
          c[r]++;
        end else begin
          r++;
          c[r] = 0;
        end
      end
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_busy",  busy_v[d],  0);
    chk("rst_done",  done_v[d],  0);
    chk("rst_found", found_v[d], 0);
    chk("rst_valid", valid_v[d], 0);
    chk("rst_row",   row_v[d],   0);
    chk("rst_idx",   idx_v[d],   0);
    chk("rst_last",  last_v[d],  0);
    chk("rst_count", cnt_v[d],   0);
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic run_search(input int d, input int stall_beat, input int stall_cycles, input bit poke);
    int n, nsol, beats;
    bit fin, stalled;
    logic [20:0] cur, held, e;
    n = n_of(d);
    build_solutions(n);
`ifdef NQUEEN_FIND_ALL_EN
    nsol = sols.size();
`else
    nsol = (sols.size() > 0) ? 1 : 0;
`endif
    exp_q.delete();
    for (int s = 0; s < nsol; s++)
      for (int i = 0; i < n; i++)
        exp_q.push_back({16'(1) << sols[s][4*i +: 4], 4'(i), 1'(i == n - 1)});
    pulse_start(d);
    chk("busy_after_start", busy_v[d], 1);
    chk("done_after_start", done_v[d], 0);
    fin = 1'b0;
    stalled = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 200000 && !fin; cyc++) begin
      @(negedge clk);
      if (done_v[d]) fin = 1'b1;
      else if (valid_v[d]) begin
        cur = {row_v[d], idx_v[d], last_v[d]};
        if (beats == stall_beat && !stalled) begin
          stalled = 1'b1;
          ready_v[d] = 1'b0;
          held = cur;
          for (int j = 0; j < stall_cycles; j++) begin
            if (poke && j == 1) start_v[d] = 1'b1;
            @(negedge clk);
            start_v[d] = 1'b0;
            chk("stall_valid", valid_v[d], 1);
            chk("stall_hold", {row_v[d], idx_v[d], last_v[d]}, held);
          end
          ready_v[d] = 1'b1;
        end
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        beats++;
      end
    end
    chk("search_timeout", fin, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("done", done_v[d], 1);
    chk("busy_in_done", busy_v[d], 0);
    chk("found", found_v[d], nsol > 0);
    chk("sol_count", cnt_v[d], nsol);
    chk("valid_in_done", valid_v[d], 0);
  endtask

  initial begin
    bit fin;
    for (int d = 0; d < 4; d++) begin
      start_v[d] = 1'b0;
      ready_v[d] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 4; d++) chk_reset(d);

    run_search(0, -1, 0, 1'b0);
    run_search(1, -1, 0, 1'b0);
    run_search(2, -1, 0, 1'b0);
    run_search(3, -1, 0, 1'b0);
    run_search(0, 3, 5, 1'b1);

    // reset while searching
    pulse_start(0);
    repeat (10) @(negedge clk);
    chk("busy_mid_check", busy_v[0], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset(0);

    // reset while a solution is streaming out
    pulse_start(0);
    fin = 1'b0;
    for (int c = 0; c < 50000 && !fin; c++) begin
      @(negedge clk);
      if (valid_v[0]) fin = 1'b1;
    end
    chk("emit_reached", fin, 1);
    @(negedge clk);
    @(negedge clk);
    chk("valid_mid_emit", valid_v[0], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset(0);
    @(negedge clk);
    chk("idle_after_reset", valid_v[0], 0);

    run_search(0, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
